// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 control slice.
package sha256_pkg;

  localparam int unsigned MAX_BYTES   = 247;
  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLR     = 4'd1,
    RX      = 4'd2,
    LEN_HI  = 4'd3,
    LEN_LO  = 4'd4,
    LDBLK   = 4'd5,
    INIT    = 4'd6,
    RUN     = 4'd7,
    NEXT    = 4'd8,
    FIN     = 4'd9,
    CLR_ERR = 4'd10
  } state_t;

  // Registered control strobes driven to the datapath.
  typedef struct packed {
    logic data_valid;
    logic padding_en;
    logic data_len_sel;
    logic len_hi_lo_sel;
    logic dp_rst;
    logic core_rst;
    logic core_en;
    logic load_hash_val;
    logic initial_hash_val;
    logic load_blocks_num;
    logic done;
    logic busy;
    logic hash_valid;
    logic err;
  } ctrl_t;

endpackage

// File: rtl/sha256_ctrl.sv
// Control FSM sequencing the SHA-256 padding unit, compression core and block counter.
// Strobes are the registered decode of the previous cycle's state and inputs, so each
// one lands in the datapath one cycle after the FSM decides on it; busy tracks the state.
module sha256_ctrl #(
  parameter int unsigned MAX_BYTES = sha256_pkg::MAX_BYTES,
  parameter int unsigned CNT_W     = sha256_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] msg_data,
  input  logic       msg_valid,
  input  logic       msg_last,
  output logic       msg_ready,
  input  logic       finish_loop,
  input  logic       is_zero,
  output logic [7:0] message,
  output logic       data_valid,
  output logic       padding_en,
  output logic       data_len_sel,
  output logic       len_hi_lo_sel,
  output logic       dp_rst,
  output logic       core_rst,
  output logic       core_en,
  output logic       load_hash_val,
  output logic       initial_hash_val,
  output logic       load_blocks_num,
  output logic       done,
  output logic       busy,
  output logic       hash_valid,
  input  logic       hash_ack,
  output logic       err
);
  import sha256_pkg::*;

  state_t           r_state;
  state_t           w_state_nxt;
  ctrl_t            r_out;
  ctrl_t            w_out_d;
  logic [7:0]       r_message;
  logic [7:0]       w_message_d;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             w_ready;
  logic             w_accept;
  logic             w_ovf;

  assign w_ready  = (r_state == RX);
  assign w_accept = msg_valid & w_ready;
  assign w_ovf    = (r_byte_cnt == CNT_W'(MAX_BYTES));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = CLR;
      CLR:     w_state_nxt = RX;
      RX: begin
        if (w_accept) begin
          if (w_ovf)         w_state_nxt = CLR_ERR;
          else if (msg_last) w_state_nxt = LEN_HI;
        end
      end
      LEN_HI:  w_state_nxt = LEN_LO;
      LEN_LO:  w_state_nxt = LDBLK;
      LDBLK:   w_state_nxt = INIT;
      INIT:    w_state_nxt = RUN;
      RUN:     if (finish_loop) w_state_nxt = NEXT;
      NEXT:    w_state_nxt = is_zero ? FIN : RUN;
      FIN:     if (hash_ack) w_state_nxt = IDLE;
      CLR_ERR: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode; an overflowing byte is dropped and only raises err.
  always_comb begin
    w_out_d      = '0;
    w_message_d  = r_message;
    w_out_d.busy = (w_state_nxt != IDLE);
    unique case (r_state)
      CLR: begin
        w_out_d.dp_rst   = 1'b1;
        w_out_d.core_rst = 1'b1;
      end
      RX: begin
        if (w_accept) begin
          if (w_ovf) begin
            w_out_d.err = 1'b1;
          end else begin
            w_out_d.data_valid = 1'b1;
            w_out_d.padding_en = 1'b1;
            w_message_d        = msg_data;
          end
        end
      end
      LEN_HI: begin
        w_out_d.data_valid    = 1'b1;
        w_out_d.padding_en    = 1'b1;
        w_out_d.data_len_sel  = 1'b1;
        w_out_d.len_hi_lo_sel = 1'b1;
      end
      LEN_LO: begin
        w_out_d.data_valid   = 1'b1;
        w_out_d.padding_en   = 1'b1;
        w_out_d.data_len_sel = 1'b1;
      end
      LDBLK: w_out_d.load_blocks_num = 1'b1;
      INIT: begin
        w_out_d.load_hash_val    = 1'b1;
        w_out_d.initial_hash_val = 1'b1;
      end
      RUN: begin
        w_out_d.core_en    = 1'b1;
        w_out_d.padding_en = 1'b1;
      end
      NEXT: begin
        w_out_d.load_hash_val = 1'b1;
        w_out_d.core_rst      = ~is_zero;
      end
      FIN: begin
        w_out_d.done       = 1'b1;
        w_out_d.hash_valid = 1'b1;
      end
      CLR_ERR: w_out_d.dp_rst = 1'b1;
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out     <= '0;
      r_message <= 8'h00;
    end else begin
      r_out     <= w_out_d;
      r_message <= w_message_d;
    end
  end

  // Accepted-byte counter, cleared at the start of every message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= '0;
    end else if (r_state == CLR) begin
      r_byte_cnt <= '0;
    end else if (w_accept && !w_ovf) begin
      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
    end
  end

  assign msg_ready        = w_ready;
  assign message          = r_message;
  assign data_valid       = r_out.data_valid;
  assign padding_en       = r_out.padding_en;
  assign data_len_sel     = r_out.data_len_sel;
  assign len_hi_lo_sel    = r_out.len_hi_lo_sel;
  assign dp_rst           = r_out.dp_rst;
  assign core_rst         = r_out.core_rst;
  assign core_en          = r_out.core_en;
  assign load_hash_val    = r_out.load_hash_val;
  assign initial_hash_val = r_out.initial_hash_val;
  assign load_blocks_num  = r_out.load_blocks_num;
  assign done             = r_out.done;
  assign busy             = r_out.busy;
  assign hash_valid       = r_out.hash_valid;
  assign err              = r_out.err;

endmodule

// File: tb/tb_sha256_ctrl.sv
// Scoreboard bench for sha256_ctrl; the bench itself plays the datapath side.
module tb_sha256_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic       msg_valid = 1'b0;
  logic       msg_last = 1'b0;
  logic       finish_loop = 1'b0;
  logic       is_zero = 1'b0;
  logic       hash_ack = 1'b0;
  logic       msg_ready, data_valid, padding_en, data_len_sel, len_hi_lo_sel;
  logic       dp_rst, core_rst, core_en, load_hash_val, initial_hash_val;
  logic       load_blocks_num, done, busy, hash_valid, err;
  logic [7:0] message;

  sha256_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_ready(msg_ready), .finish_loop(finish_loop), .is_zero(is_zero),
    .message(message), .data_valid(data_valid), .padding_en(padding_en),
    .data_len_sel(data_len_sel), .len_hi_lo_sel(len_hi_lo_sel), .dp_rst(dp_rst),
    .core_rst(core_rst), .core_en(core_en), .load_hash_val(load_hash_val),
    .initial_hash_val(initial_hash_val), .load_blocks_num(load_blocks_num), .done(done),
    .busy(busy), .hash_valid(hash_valid), .hash_ack(hash_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_DATA, EV_LHI, EV_LLO, EV_ERR, EV_HASH} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        sbq[$];
  logic [7:0] msgq[$];
  int         checks = 0;
  int         failures = 0;
  int         dv_bytes = 0;
  logic       prev_hv = 1'b0;
  ev_kind_t   mon_kind;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic expect_event(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d expected=none at %0t", int'(k), $time);
    end else begin
      e = sbq.pop_front();
      chk("event_kind", 32'(int'(k)), 32'(int'(e.kind)));
      if (e.kind == EV_DATA && k == EV_DATA) chk("event_byte", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: every strobe the DUT raises must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) begin
        mon_kind = data_len_sel ? (len_hi_lo_sel ? EV_LHI : EV_LLO) : EV_DATA;
        if (!data_len_sel) dv_bytes++;
        expect_event(mon_kind, message);
        chk("dv_padding_en", 32'(padding_en), 32'd1);
      end
      if (err) expect_event(EV_ERR, 8'h00);
      if (hash_valid && !prev_hv) expect_event(EV_HASH, 8'h00);
      prev_hv = hash_valid;
    end else begin
      prev_hv = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_ready", 32'(msg_ready), 32'd0);
    tick();
    chk("clr_dp_rst", 32'({dp_rst, core_rst}), 32'b11);
    chk("rx_ready", 32'(msg_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input bit ovf);
    int n = 0;
    msg_data  = d;
    msg_valid = 1'b1;
    msg_last  = last;
    while (!msg_ready && n < 20) begin
      tick();
      n++;
    end
    if (!msg_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual_ready=0 expected_ready=1 at %0t", $time);
    end else begin
      push(ovf ? EV_ERR : EV_DATA, d);
      if (last && !ovf) begin
        push(EV_LHI, 8'h00);
        push(EV_LLO, 8'h00);
      end
    end
    tick();
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic send_queue();
    for (int i = 0; i < msgq.size(); i++) send_byte(msgq[i], i == msgq.size() - 1, 1'b0);
  endtask

  task automatic wait_core_en();
    int n = 0;
    while (!core_en && n < 20) begin
      tick();
      n++;
    end
    chk("core_en_wait", 32'(core_en), 32'd1);
  endtask

  // Entered one cycle after the last byte was accepted.
  task automatic run_blocks(input int nblk);
    tick(3);
    chk("load_blocks_num", 32'(load_blocks_num), 32'd1);
    tick();
    chk("init_hash", 32'({load_hash_val, initial_hash_val}), 32'b11);
    for (int b = 0; b < nblk; b++) begin
      wait_core_en();
      tick(2);
      chk("run_strobes", 32'({core_en, padding_en, load_hash_val}), 32'b110);
      if (b == nblk - 1) push(EV_HASH, 8'h00);
      finish_loop = 1'b1;
      is_zero     = (b == nblk - 1);
      tick();
      finish_loop = 1'b0;
      tick();
      is_zero = 1'b0;
      chk("next_load_hash", 32'({load_hash_val, initial_hash_val}), 32'b10);
      chk("next_core_rst", 32'(core_rst), (b == nblk - 1) ? 32'd0 : 32'd1);
      chk("next_core_en", 32'(core_en), 32'd0);
    end
    tick();
    chk("fin_valid", 32'({done, hash_valid, busy}), 32'b111);
  endtask

  task automatic ack_fin(input int hold);
    for (int i = 0; i < hold; i++) begin
      start = (i % 5 == 0);
      tick();
      chk("fin_hold", 32'({done, hash_valid, busy}), 32'b111);
    end
    start    = 1'b0;
    hash_ack = 1'b1;
    tick();
    hash_ack = 1'b0;
    chk("ack_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("ack_drop", 32'({done, hash_valid, busy}), 32'b000);
  endtask

  task automatic load_abc();
    msgq = {8'h61, 8'h62, 8'h63};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0;
    tick(2);
    chk("reset_outputs", 32'({message, data_valid, padding_en, data_len_sel, len_hi_lo_sel,
        dp_rst, core_rst, core_en, load_hash_val, initial_hash_val, load_blocks_num,
        done, busy, hash_valid, err, msg_ready}), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // msg_valid and finish_loop in IDLE are ignored.
    msg_valid   = 1'b1;
    finish_loop = 1'b1;
    tick(3);
    chk("idle_ready", 32'(msg_ready), 32'd0);
    chk("idle_no_run", 32'({core_en, busy}), 32'b00);
    msg_valid   = 1'b0;
    finish_loop = 1'b0;

    // "abc": one block.
    do_start();
    load_abc();
    send_queue();
    run_blocks(1);
    ack_fin(1);

    // 56-byte "abcdbcde...nopq": two blocks, slow acknowledge with start pulses.
    do_start();
    msgq = {};
    for (int i = 0; i < 14; i++)
      for (int k = 0; k < 4; k++) msgq.push_back(8'(8'h61 + i + k));
    send_queue();
    run_blocks(2);
    ack_fin(20);

    // 10 bytes with msg_valid toggling; finish_loop in RX is ignored.
    dv0 = dv_bytes;
    do_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(8'hA0 + i), i == 9, 1'b0);
      if (i < 9) begin
        finish_loop = (i == 4);
        tick();
        finish_loop = 1'b0;
        chk("rx_gap", 32'({msg_ready, core_en}), 32'b10);
      end
    end
    run_blocks(1);
    ack_fin(1);
    chk("toggle_byte_count", 32'(dv_bytes - dv0), 32'd10);

    // 248 bytes without msg_last: the last one overflows.
    do_start();
    for (int i = 0; i < 247; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b1);
    chk("ovf_err", 32'({err, msg_ready, busy}), 32'b101);
    tick();
    chk("ovf_clr", 32'({err, dp_rst, busy, hash_valid}), 32'b0100);
    tick();
    chk("ovf_idle", 32'({dp_rst, busy, hash_valid}), 32'b000);

    // Reset during RUN, then a fresh "abc".
    do_start();
    load_abc();
    send_queue();
    tick(5);
    chk("pre_reset_run", 32'(core_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", 32'({message, data_valid, padding_en, core_en, busy, hash_valid,
        load_hash_val, core_rst, dp_rst, msg_ready}), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    do_start();
    load_abc();
    send_queue();
    run_blocks(1);
    ack_fin(1);

    // One-byte message.
    do_start();
    msgq = {8'h5A};
    send_queue();
    run_blocks(1);
    ack_fin(2);

    tick(3);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
